// File: rtl/cla_adde16b.sv
// ============================================================================
// Module   : cla_adde16b
// Purpose  : 16-bit two-level carry-lookahead adder, r = a + b + c_in.
//            Sum and carry-out are combinational.  A registered copy of the
//            result is captured on every rising clk edge.
// Ports    : clk      - clock, rising edge updates registered outputs
//            rst      - synchronous active-high reset of registered outputs
//            a, b     - 16-bit addends
//            c_in     - carry into bit 0
//            r        - combinational sum [15:0]
//            c_out    - combinational carry out of bit 15
//            r_q      - registered r
//            c_out_q  - registered c_out
//            ovf      - combinational signed overflow (CLA_ADDE_OVF_EN only)
//            ovf_q    - registered ovf (CLA_ADDE_OVF_EN only)
// Config   : define CLA_ADDE_OVF_EN to add the signed-overflow ports/logic.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_adde16b (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        c_in,
  output logic [15:0] r,
  output logic        c_out,
  output logic [15:0] r_q,
  output logic        c_out_q
`ifdef CLA_ADDE_OVF_EN
  ,
  output logic        ovf,
  output logic        ovf_q
`endif
);

  localparam int NUM_GROUPS = 4;

  logic [15:0] g;      // bit generate
  logic [15:0] p;      // bit propagate
  logic [15:0] carry;  // carry into each bit position
  logic [3:0]  gg;     // group generate
  logic [3:0]  gp;     // group propagate
  logic [4:0]  gc;     // group carries: gc[k] feeds group k, gc[4] = C16

  assign g = a & b;
  assign p = a ^ b;

  // First level: each group looks ahead over its own four bits using only
  // its group carry-in, so nothing ripples bit-to-bit inside a group.
  generate
    for (genvar k = 0; k < NUM_GROUPS; k++) begin : g_grp
      logic [3:0] gl;
      logic [3:0] pl;
      logic       ci;

      assign gl = g[4*k +: 4];
      assign pl = p[4*k +: 4];
      assign ci = gc[k];

      assign carry[4*k]   = ci;
      assign carry[4*k+1] = gl[0] | (pl[0] & ci);
      assign carry[4*k+2] = gl[1] | (pl[1] & gl[0]) | (pl[1] & pl[0] & ci);
      assign carry[4*k+3] = gl[2] | (pl[2] & gl[1]) | (pl[2] & pl[1] & gl[0])
                          | (pl[2] & pl[1] & pl[0] & ci);

      assign gg[k] = gl[3] | (pl[3] & gl[2]) | (pl[3] & pl[2] & gl[1])
                   | (pl[3] & pl[2] & pl[1] & gl[0]);
      assign gp[k] = &pl;
    end
  endgenerate

  // Second level: every group carry is expanded directly from c_in so the
  // group carries do not ripple across groups either.
  assign gc[0] = c_in;
  assign gc[1] = gg[0] | (gp[0] & c_in);
  assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
  assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
               | (gp[2] & gp[1] & gp[0] & c_in);
  assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
               | (gp[3] & gp[2] & gp[1] & gg[0])
               | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);

  assign r     = p ^ carry;
  assign c_out = gc[4];

`ifdef CLA_ADDE_OVF_EN
  // Signed overflow: carry into the sign bit differs from carry out of it.
  assign ovf = gc[4] ^ carry[15];

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= ovf;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q     <= 16'h0000;
      c_out_q <= 1'b0;
    end else begin
      r_q     <= r;
      c_out_q <= c_out;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cla_adde16b.sv
// ============================================================================
// Module   : tb_cla_adde16b
// Purpose  : Self-checking bench for cla_adde16b.  Directed table vectors and
//            a random sweep check the combinational outputs 1 ns after the
//            inputs change; expected registered values go into a scoreboard
//            queue and are popped and compared after the next rising edge.
//            Hand-written sequences cover reset behaviour.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cla_adde16b;

  logic        clk;
  logic        rst;
  logic [15:0] a;
  logic [15:0] b;
  logic        c_in;
  logic [15:0] r;
  logic        c_out;
  logic [15:0] r_q;
  logic        c_out_q;
`ifdef CLA_ADDE_OVF_EN
  logic        ovf;
  logic        ovf_q;
`endif

  cla_adde16b dut (
    .clk     (clk),
    .rst     (rst),
    .a       (a),
    .b       (b),
    .c_in    (c_in),
    .r       (r),
    .c_out   (c_out),
    .r_q     (r_q),
    .c_out_q (c_out_q)
`ifdef CLA_ADDE_OVF_EN
    ,
    .ovf     (ovf),
    .ovf_q   (ovf_q)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] er;
    logic        ec;
    logic        eo;
  } vec_t;

  typedef struct packed {
    logic [15:0] r;
    logic        c;
    logic        o;
  } exp_t;

  localparam int NVEC = 13;

  vec_t tbl [NVEC];
  exp_t sbq [$];
  int   checks;
  int   errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive one vector after a falling edge, check the combinational outputs
  // 1 ns later, and queue the values the registers should capture.
  task automatic drive_and_check(input string name, input logic [15:0] va,
                                 input logic [15:0] vb, input logic vc,
                                 input logic [15:0] er, input logic ec,
                                 input logic eo);
    exp_t e;
    @(negedge clk);
    a = va; b = vb; c_in = vc;
    #1;
    chk({name, ".r"}, {16'h0, r}, {16'h0, er});
    chk({name, ".c_out"}, {31'h0, c_out}, {31'h0, ec});
`ifdef CLA_ADDE_OVF_EN
    chk({name, ".ovf"}, {31'h0, ovf}, {31'h0, eo});
`endif
    e.r = er; e.c = ec; e.o = eo;
    sbq.push_back(e);
  endtask

  // Pop the oldest expectation after the next rising edge and compare.
  task automatic clock_and_pop(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (sbq.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s.scoreboard: got empty queue expected an entry", name);
    end else begin
      e = sbq.pop_front();
      chk({name, ".r_q"}, {16'h0, r_q}, {16'h0, e.r});
      chk({name, ".c_out_q"}, {31'h0, c_out_q}, {31'h0, e.c});
`ifdef CLA_ADDE_OVF_EN
      chk({name, ".ovf_q"}, {31'h0, ovf_q}, {31'h0, e.o});
`endif
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1; a = 16'h0; b = 16'h0; c_in = 1'b0;

    //          a         b         cin   r         c_out ovf
    tbl[0]  = '{16'd1,     16'd2,     1'b0, 16'd3,     1'b0, 1'b0};
    tbl[1]  = '{16'd20000, 16'd14,    1'b1, 16'd20015, 1'b0, 1'b0};
    tbl[2]  = '{16'd12356, 16'd14500, 1'b0, 16'd26856, 1'b0, 1'b0};
    tbl[3]  = '{16'hFFFF,  16'h0001,  1'b0, 16'h0000,  1'b1, 1'b0};
    tbl[4]  = '{16'h7FFF,  16'h0001,  1'b0, 16'h8000,  1'b0, 1'b1};
    tbl[5]  = '{16'hFFFF,  16'h0000,  1'b1, 16'h0000,  1'b1, 1'b0};
    tbl[6]  = '{16'hFFFF,  16'hFFFF,  1'b1, 16'hFFFF,  1'b1, 1'b0};
    tbl[7]  = '{16'h0000,  16'h0000,  1'b0, 16'h0000,  1'b0, 1'b0};
    tbl[8]  = '{16'h000F,  16'h0001,  1'b0, 16'h0010,  1'b0, 1'b0};
    tbl[9]  = '{16'h00FF,  16'h0001,  1'b0, 16'h0100,  1'b0, 1'b0};
    tbl[10] = '{16'h0FFF,  16'h0001,  1'b0, 16'h1000,  1'b0, 1'b0};
    tbl[11] = '{16'h8000,  16'h8000,  1'b0, 16'h0000,  1'b1, 1'b1};
    tbl[12] = '{16'h7FFF,  16'h7FFF,  1'b1, 16'hFFFF,  1'b0, 1'b1};

    // Reset state of the registers.
    @(posedge clk);
    #1;
    chk("reset.r_q", {16'h0, r_q}, 32'h0);
    chk("reset.c_out_q", {31'h0, c_out_q}, 32'h0);
`ifdef CLA_ADDE_OVF_EN
    chk("reset.ovf_q", {31'h0, ovf_q}, 32'h0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // Directed table.
    for (int i = 0; i < NVEC; i++) begin
      drive_and_check($sformatf("vec%0d", i), tbl[i].a, tbl[i].b, tbl[i].cin,
                      tbl[i].er, tbl[i].ec, tbl[i].eo);
      clock_and_pop($sformatf("vec%0d", i));
    end

    // Reset while the registers hold non-zero values; the adder itself
    // keeps producing the sum.
    drive_and_check("pre_rst", 16'h7FFF, 16'h7FFF, 1'b1, 16'hFFFF, 1'b0, 1'b1);
    clock_and_pop("pre_rst");
    @(negedge clk);
    rst = 1'b1; a = 16'h1234; b = 16'h1111; c_in = 1'b0;
    #1;
    chk("rst.r", {16'h0, r}, 32'h2345);
    chk("rst.c_out", {31'h0, c_out}, 32'h0);
    @(posedge clk);
    #1;
    chk("rst.r_q", {16'h0, r_q}, 32'h0);
    chk("rst.c_out_q", {31'h0, c_out_q}, 32'h0);
`ifdef CLA_ADDE_OVF_EN
    chk("rst.ovf_q", {31'h0, ovf_q}, 32'h0);
`endif
    chk("rst.r_hold", {16'h0, r}, 32'h2345);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rel.r_q", {16'h0, r_q}, 32'h2345);
    chk("rel.c_out_q", {31'h0, c_out_q}, 32'h0);

    // Random sweep against a behavioural 17-bit model.
    for (int i = 0; i < 10000; i++) begin
      logic [15:0] ra, rb;
      logic        rc;
      logic [16:0] sum;
      logic        so;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom);
      sum = {1'b0, ra} + {1'b0, rb} + {16'h0, rc};
      so  = (ra[15] == rb[15]) && (sum[15] != ra[15]);
      drive_and_check("rand", ra, rb, rc, sum[15:0], sum[16], so);
      clock_and_pop("rand");
    end

    if (sbq.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard.drain: got %0d leftover entries expected 0", sbq.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
